// File: rtl/spu_issue_pkg.sv
// Shared definitions for the SPU dual-pipe issue queue: pipe classification,
// NOP encoding and the issue decision type.
package spu_issue_pkg;

    localparam logic [0:1]  ODD_OPCODE = 2'b01;
    localparam logic [0:31] NOP_WORD   = 32'h0000_0000;

    typedef enum logic {
        PIPE_EVEN = 1'b0,
        PIPE_ODD  = 1'b1
    } pipe_e;

    typedef enum logic [1:0] {
        ISSUE_NONE   = 2'd0,
        ISSUE_SINGLE = 2'd1,
        ISSUE_DUAL   = 2'd2
    } issue_e;

    function automatic pipe_e pipe_class(input logic [0:31] instr);
        return (instr[0:1] == ODD_OPCODE) ? PIPE_ODD : PIPE_EVEN;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Circular instruction store with two write and two read ports. Writes and
// reads are compacted: port 0 is always the first slot, port 1 the second.
module issue_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [1:0]               wr_cnt,
    input  logic [0:31]              wr_data0,
    input  logic [0:31]              wr_data1,
    input  logic [1:0]               rd_cnt,
    output logic [0:31]              rd_data0,
    output logic [0:31]              rd_data1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [0:31]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage carries no reset; count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (wr_cnt != 2'd0) begin
            mem[wr_ptr] <= wr_data0;
        end
        if (wr_cnt == 2'd2) begin
            mem[wr_ptr + PW'(1)] <= wr_data1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr_cnt);
            rd_ptr <= rd_ptr + PW'(rd_cnt);
            count  <= count + CW'(wr_cnt) - CW'(rd_cnt);
        end
    end

    assign rd_data0 = mem[rd_ptr];
    assign rd_data1 = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/issue_queue.sv
// In-order dual-pipe issue queue: accepts fetch pairs, drops NOP slots, and
// issues an even/odd pair together when program order allows it.
module issue_queue
    import spu_issue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [0:31]            in_instr0,
    input  logic [0:31]            in_instr1,
    output logic                   in_ready,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   even_valid,
    output logic [0:31]            even_instr,
    output logic                   odd_valid,
    output logic [0:31]            odd_instr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: a pair transfers on a rising edge where in_valid and in_ready
    // are both high (and flush is low); in_ready depends only on count, so it
    // never reacts combinationally to in_valid or to a same-cycle dequeue.
    logic [CW-1:0] free_slots;
    logic          accept;
    logic          slot0_live;
    logic          slot1_live;
    logic [1:0]    wr_cnt;
    logic [0:31]   wr_data0;
    logic [1:0]    rd_cnt;
    logic [0:31]   head_instr;
    logic [0:31]   next_instr;
    issue_e        issue_mode;

    assign free_slots = CW'(DEPTH) - count;
    assign in_ready   = (free_slots >= CW'(2));
    assign accept     = in_valid && in_ready && !flush;
    assign slot0_live = (in_instr0 != NOP_WORD);
    assign slot1_live = (in_instr1 != NOP_WORD);

    always_comb begin
        wr_cnt   = 2'd0;
        wr_data0 = in_instr0;
        if (accept) begin
            wr_cnt = {1'b0, slot0_live} + {1'b0, slot1_live};
        end
        if (!slot0_live) begin
            wr_data0 = in_instr1;
        end
    end

    // A younger odd entry may only pair with an even head; an odd head always
    // goes alone so nothing overtakes it.
    always_comb begin
        issue_mode = ISSUE_NONE;
        rd_cnt     = 2'd0;
        if (count != '0) begin
            if (pipe_class(head_instr) == PIPE_EVEN && count >= CW'(2) &&
                pipe_class(next_instr) == PIPE_ODD) begin
                issue_mode = ISSUE_DUAL;
            end else begin
                issue_mode = ISSUE_SINGLE;
            end
        end
        if (!stall && !flush) begin
            case (issue_mode)
                ISSUE_DUAL:   rd_cnt = 2'd2;
                ISSUE_SINGLE: rd_cnt = 2'd1;
                default:      rd_cnt = 2'd0;
            endcase
        end
    end

    issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .wr_cnt   (wr_cnt),
        .wr_data0 (wr_data0),
        .wr_data1 (in_instr1),
        .rd_cnt   (rd_cnt),
        .rd_data0 (head_instr),
        .rd_data1 (next_instr),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            even_valid <= 1'b0;
            even_instr <= '0;
            odd_valid  <= 1'b0;
            odd_instr  <= '0;
        end else if (flush) begin
            even_valid <= 1'b0;
            even_instr <= '0;
            odd_valid  <= 1'b0;
            odd_instr  <= '0;
        end else if (!stall) begin
            case (issue_mode)
                ISSUE_DUAL: begin
                    even_valid <= 1'b1;
                    even_instr <= head_instr;
                    odd_valid  <= 1'b1;
                    odd_instr  <= next_instr;
                end
                ISSUE_SINGLE: begin
                    if (pipe_class(head_instr) == PIPE_ODD) begin
                        even_valid <= 1'b0;
                        even_instr <= '0;
                        odd_valid  <= 1'b1;
                        odd_instr  <= head_instr;
                    end else begin
                        even_valid <= 1'b1;
                        even_instr <= head_instr;
                        odd_valid  <= 1'b0;
                        odd_instr  <= '0;
                    end
                end
                default: begin
                    even_valid <= 1'b0;
                    even_instr <= '0;
                    odd_valid  <= 1'b0;
                    odd_instr  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: expected issue bundles are queued with the
// stimulus and a negedge monitor compares each fresh issue against them.
module tb_issue_queue;

  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [0:31]   in_instr0;
  logic [0:31]   in_instr1;
  logic          in_ready;
  logic          stall;
  logic          flush;
  logic          even_valid;
  logic [0:31]   even_instr;
  logic          odd_valid;
  logic [0:31]   odd_instr;
  logic [CW-1:0] count;

  logic [65:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        issued_edge = 1'b0;

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_instr0  (in_instr0),
    .in_instr1  (in_instr1),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .even_valid (even_valid),
    .even_instr (even_instr),
    .odd_valid  (odd_valid),
    .odd_instr  (odd_instr),
    .count      (count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------- driver tasks ----------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [0:31] i0, input logic [0:31] i1);
    in_valid  = 1'b1;
    in_instr0 = i0;
    in_instr1 = i1;
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    in_instr0 = '0;
    in_instr1 = '0;
  endtask

  task automatic expect_issue(input logic ev, input logic [0:31] ei,
                              input logic ov, input logic [0:31] oi);
    exp_q.push_back({ev, ei, ov, oi});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------- scoreboard monitor ----------
  always @(posedge clk) begin
    issued_edge = rst_n && !stall && !flush;
  end

  always @(negedge clk) begin
    logic [65:0] act;
    logic [65:0] exp;
    act = {even_valid, even_instr, odd_valid, odd_instr};
    if (issued_edge && (even_valid || odd_valid)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL issue_unexpected: got %h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_bad++;
          $display("FAIL issue_bundle: got %h expected %h", act, exp);
        end
      end
    end
  end

  // ---------- stimulus ----------
  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    idle_in();
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_valids", {30'd0, even_valid, odd_valid}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // dual issue
    drive_pair(32'h1000_0001, 32'h4000_0002);
    expect_issue(1'b1, 32'h1000_0001, 1'b1, 32'h4000_0002);
    step();
    idle_in();
    check("dual_count_after_accept", 32'(count), 32'd2);
    check("dual_not_yet_valid", {30'd0, even_valid, odd_valid}, 32'd0);
    step();
    check("dual_even_instr", even_instr, 32'h1000_0001);
    check("dual_odd_instr", odd_instr, 32'h4000_0002);
    check("dual_valids", {30'd0, even_valid, odd_valid}, 32'd3);
    step();
    check("dual_drained_valids", {30'd0, even_valid, odd_valid}, 32'd0);

    // ordering: odd head followed by even
    drive_pair(32'h4000_0002, 32'h1000_0001);
    expect_issue(1'b0, 32'h0, 1'b1, 32'h4000_0002);
    expect_issue(1'b1, 32'h1000_0001, 1'b0, 32'h0);
    step();
    idle_in();
    step();
    check("order_first_odd", {30'd0, even_valid, odd_valid}, 32'd1);
    check("order_first_even_instr_zero", even_instr, 32'h0);
    step();
    check("order_second_even", {30'd0, even_valid, odd_valid}, 32'd2);
    check("order_second_odd_instr_zero", odd_instr, 32'h0);
    step();

    // NOP drop and stall hold
    drive_pair(32'h3000_0005, 32'h0);
    expect_issue(1'b1, 32'h3000_0005, 1'b0, 32'h0);
    step();
    check("nop_drop_single", 32'(count), 32'd1);
    idle_in();
    step();
    stall = 1'b1;
    drive_pair(32'h0, 32'h1000_0001);
    step();
    check("stall1_count", 32'(count), 32'd1);
    check("stall1_even_instr", even_instr, 32'h3000_0005);
    drive_pair(32'h2000_0003, 32'h5000_0004);
    step();
    check("stall2_count", 32'(count), 32'd3);
    check("stall2_even_instr", even_instr, 32'h3000_0005);
    drive_pair(32'h6000_0006, 32'h0);
    step();
    check("stall3_count", 32'(count), 32'd4);
    check("stall3_valids", {30'd0, even_valid, odd_valid}, 32'd2);
    check("stall3_even_instr", even_instr, 32'h3000_0005);
    idle_in();
    stall = 1'b0;
    expect_issue(1'b1, 32'h1000_0001, 1'b0, 32'h0);
    expect_issue(1'b1, 32'h2000_0003, 1'b1, 32'h5000_0004);
    expect_issue(1'b0, 32'h0, 1'b1, 32'h6000_0006);
    repeat (4) step();
    check("stall_drain_count", 32'(count), 32'd0);

    // full and wrap: fill under stall, then drain, four rounds
    for (int r = 0; r < 4; r++) begin
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
        logic [0:31] e;
        logic [0:31] o;
        e = 32'h1000_0000 + 32'(r * 16 + k);
        o = 32'h4000_0000 + 32'(r * 16 + k);
        drive_pair(e, o);
        expect_issue(1'b1, e, 1'b1, o);
        step();
      end
      check("full_count", 32'(count), 32'd8);
      check("full_in_ready", 32'(in_ready), 32'd0);
      drive_pair(32'h1EEE_EEEE, 32'h4EEE_EEEE);
      step();
      check("full_reject_count", 32'(count), 32'd8);
      idle_in();
      stall = 1'b0;
      repeat (5) step();
      check("wrap_drain_count", 32'(count), 32'd0);
    end

    // flush overrides stall and enqueue
    drive_pair(32'h1000_0001, 32'h4000_0002);
    expect_issue(1'b1, 32'h1000_0001, 1'b1, 32'h4000_0002);
    step();
    idle_in();
    step();
    stall = 1'b1;
    drive_pair(32'h2000_0003, 32'h0);
    step();
    check("preflush_count", 32'(count), 32'd1);
    flush = 1'b1;
    drive_pair(32'h3000_0005, 32'h5000_0004);
    step();
    check("flush_count", 32'(count), 32'd0);
    check("flush_valids", {30'd0, even_valid, odd_valid}, 32'd0);
    check("flush_even_instr", even_instr, 32'h0);
    flush = 1'b0;
    stall = 1'b0;
    idle_in();
    repeat (3) step();
    check("postflush_valids", {30'd0, even_valid, odd_valid}, 32'd0);

    // reset mid-stream with count=5
    drive_pair(32'h3000_0005, 32'h0);
    expect_issue(1'b1, 32'h3000_0005, 1'b0, 32'h0);
    step();
    idle_in();
    step();
    stall = 1'b1;
    drive_pair(32'h1000_0011, 32'h2000_0022);
    step();
    drive_pair(32'h1000_0033, 32'h2000_0044);
    step();
    drive_pair(32'h1000_0055, 32'h0);
    step();
    idle_in();
    check("prereset_count", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_valids", {30'd0, even_valid, odd_valid}, 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_even_instr", even_instr, 32'h0);
    step();
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (3) step();
    check("postreset_valids", {30'd0, even_valid, odd_valid}, 32'd0);
    check("postreset_count", 32'(count), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
